// File: rtl/mux_3_pkg.sv
// Shared constants for the registered 3-input selector.
// Holds the select encodings and the default data/output widths.
// Imported by mux_3. It has no ports and no logic.
package mux_3_pkg;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    localparam int DATA_W_DEF = 8;
    localparam int OUT_W_DEF  = 16;

endpackage

// File: rtl/mux_3.sv
// Purpose: registered 3-input selector. It picks in_A, in_B or in_C and
//   zero-extends the chosen input to OUT_W bits. Select 00 clears the output.
// Latency: one clk. out is the select/data value sampled at the previous rising edge.
// Backpressure: none. A new value is accepted on every edge.
// Ports: clk, rst (sync, active-high); in_A/in_B/in_C [0:DATA_W-1] (index 0 = MSB);
//   select [1:0]; out [0:OUT_W-1] (index 0 = MSB). The upper OUT_W-DATA_W bits are zero.
module mux_3
    import mux_3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:DATA_W-1] in_A,
    input  logic [0:DATA_W-1] in_B,
    input  logic [0:DATA_W-1] in_C,
    input  logic [1:0]        select,
    output logic [0:OUT_W-1]  out
);

    // Ascending ranges put the LSB at the highest index. The input therefore lands
    // in the last DATA_W positions of the result, and numeric value is preserved.
    function automatic logic [0:OUT_W-1] zext(input logic [0:DATA_W-1] d);
        logic [0:OUT_W-1] r;
        r = '0;
        r[OUT_W-DATA_W +: DATA_W] = d;
        return r;
    endfunction

    logic [0:OUT_W-1] out_d;
    logic [0:OUT_W-1] out_q;

    always_comb begin
        out_d = '0;
        case (select)
            SEL_IDLE: out_d = '0;
            SEL_A:    out_d = zext(in_A);
            SEL_B:    out_d = zext(in_B);
            SEL_C:    out_d = zext(in_C);
            // An unknown select must show up on out rather than alias to a source.
            default:  out_d = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mux_3.sv
module tb_mux_3;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:7]  in_A, in_B, in_C;
    logic [1:0]  select;
    logic [0:15] out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_3 dut (
        .clk    (clk),
        .rst    (rst),
        .in_A   (in_A),
        .in_B   (in_B),
        .in_C   (in_C),
        .select (select),
        .out    (out)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a table indexed by select. Entry 0 is the idle value.
    // The output is the table entry seen at the last edge, or 0 under reset.
    logic [15:0] src_tbl [4];
    logic [15:0] model_q;
    bit          model_vld = 1'b0;

    always @(posedge clk) begin
        src_tbl[0] = 16'd0;
        src_tbl[1] = 16'(in_A);
        src_tbl[2] = 16'(in_B);
        src_tbl[3] = 16'(in_C);
        if (rst === 1'b1) begin
            model_q   <= 16'd0;
            model_vld <= 1'b1;
        end else begin
            model_q <= src_tbl[select];
        end
    end

    always @(negedge clk) begin
        if (model_vld) begin
            check("model", out, model_q);
            check("upper_zero", {8'h00, out[0:7]}, 16'd0);
        end
    end

    // Drives the inputs just after an edge, then steps to just after the next edge.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [1:0] s);
        rst = r; in_A = a; in_B = b; in_C = c; select = s;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  il_sel [5];
    logic [15:0] il_exp [5];

    initial begin
        rst = 1'b0; in_A = '0; in_B = '0; in_C = '0; select = 2'b00;
        @(posedge clk);
        #1;

        // Reset is held for two edges while select points at C.
        apply(1'b1, 8'd2, 8'd4, 8'd1, 2'b11);
        check("reset_edge1", out, 16'd0);
        apply(1'b1, 8'd2, 8'd4, 8'd1, 2'b11);
        check("reset_edge2", out, 16'd0);

        // Source A, with a check before the edge to confirm the one-clock latency.
        rst = 1'b0; select = 2'b01;
        #2;
        check("a_before_edge", out, 16'd0);
        @(posedge clk);
        #1;
        check("source_a", out, 16'd2);

        apply(1'b0, 8'd2, 8'd4, 8'd1, 2'b10);
        check("source_b", out, 16'd4);
        apply(1'b0, 8'd2, 8'd4, 8'd1, 2'b11);
        check("source_c", out, 16'd1);

        // Idle codes interleaved with the three sources.
        il_sel = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b10};
        il_exp = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd4};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 8'd2, 8'd4, 8'd1, il_sel[i]);
            check($sformatf("interleave_%0d", i), out, il_exp[i]);
        end

        // Only the select present at the edge matters.
        apply(1'b0, 8'd2, 8'd4, 8'd1, 2'b01);
        check("pre_glitch", out, 16'd2);
        select = 2'b11;
        #2 select = 2'b00;
        #1 select = 2'b10;
        @(posedge clk);
        #1;
        check("glitch_ignored", out, 16'd4);

        // Zero-extension of a full-scale input.
        apply(1'b0, 8'hFF, 8'd4, 8'd1, 2'b01);
        check("extend_ff", out, 16'h00FF);
        apply(1'b0, 8'h80, 8'h01, 8'd1, 2'b10);
        check("extend_lsb", out, 16'h0001);

        // Reset mid-stream wins over select, and operation resumes on the next edge.
        apply(1'b0, 8'd2, 8'd4, 8'd1, 2'b10);
        check("prio_before", out, 16'd4);
        apply(1'b1, 8'd2, 8'd4, 8'd1, 2'b10);
        check("prio_reset", out, 16'd0);
        apply(1'b0, 8'd2, 8'd4, 8'd1, 2'b10);
        check("prio_resume", out, 16'd4);

        // Select changes at the same edge as reset; the new select is used after reset.
        apply(1'b1, 8'h5A, 8'd4, 8'd1, 2'b01);
        check("prio_sel_change", out, 16'd0);
        apply(1'b0, 8'h5A, 8'd4, 8'd1, 2'b01);
        check("prio_new_sel", out, 16'h005A);

        apply(1'b0, 8'h5A, 8'd4, 8'hC3, 2'b11);
        check("source_c_c3", out, 16'h00C3);
        apply(1'b0, 8'h5A, 8'd4, 8'hC3, 2'b00);
        check("final_idle", out, 16'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
